dmem_responder: RTL

Multi-cycle data-memory responder on the pipeline's MEM stage interface. Accepts one load/store request from the MEM stage and services it from an internal word array after a fixed latency. Holds `stall_o` high while busy so the pipeline freezes, then pulses `ack_o` for one cycle with read data. Replaces the single-cycle data memory when modelling realistic memory latency.

---
 rtl/dmem_responder.sv | 106 ++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts one load/store,
// stalls the pipeline for LATENCY cycles, then acks with registered data/error.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH];

  logic          commit;
  logic          op_we;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic          op_err;
  logic [AW-1:0] op_idx;

  // With LATENCY=1 the commit edge is the accept edge, so the operation is
  // taken straight from the inputs instead of the capture registers.
  always_comb begin
    commit   = (state == WAIT && cnt == CW'(1)) ||
               (state == IDLE && req_i && (LATENCY == 32'd1));
    op_we    = (state == IDLE) ? we_i    : we_q;
    op_addr  = (state == IDLE) ? addr_i  : addr_q;
    op_wdata = (state == IDLE) ? wdata_i : wdata_q;
    op_err   = (op_addr[1:0] != 2'b00) || ((op_addr >> (AW + 2)) != '0);
    op_idx   = op_addr[AW+1:2];
  end

  always_comb begin
    stall_o = (state == IDLE && req_i) || (state == WAIT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      ack_o <= commit;
      if (commit) begin
        err_o   <= op_err;
        rdata_o <= (op_err || op_we) ? '0 : mem[op_idx];
      end
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            cnt     <= CW'(LATENCY - 1);
            if (LATENCY > 1) state <= WAIT;
            else             state <= RESP;
          end
        end
        WAIT: begin
          if (cnt == CW'(1)) begin
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; a store still in flight when reset hits is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit && op_we && !op_err) begin
      mem[op_idx] <= op_wdata;
    end
  end

endmodule
